// File: rtl/hmac512_pkg.sv
// Shared types for the SHA-512 message path: FIFO entry, 64-bit word and the
// packer state encoding, plus small strobe/mask helpers.
package hmac512_pkg;

  typedef logic [63:0] sha_word_t;

  typedef struct packed {
    sha_word_t   data;
    logic [7:0]  mask;
  } sha_fifo_t;

  typedef enum logic [2:0] {
    StIdle,
    StAccum,
    StFlush,
    StDrain,
    StDone
  } pack_st_e;

  typedef struct packed {
    logic       legal;
    logic [2:0] nbytes;
  } strb_info_t;

  // Only contiguous low-lane strobes carry bytes; anything else is rejected.
  function automatic strb_info_t decode_strb(input logic [3:0] strb);
    strb_info_t info;
    info = '{legal: 1'b1, nbytes: 3'd0};
    case (strb)
      4'b0000: info.nbytes = 3'd0;
      4'b0001: info.nbytes = 3'd1;
      4'b0011: info.nbytes = 3'd2;
      4'b0111: info.nbytes = 3'd3;
      4'b1111: info.nbytes = 3'd4;
      default: info.legal  = 1'b0;
    endcase
    return info;
  endfunction

  // Residue mask: one bit per valid byte, first byte in the MSB.
  function automatic logic [7:0] residue_mask(input logic [3:0] ptr);
    return ~(8'hFF >> ptr);
  endfunction

endpackage

// File: rtl/sha512_msg_pack.sv
// Packs 32-bit register writes into big-endian 64-bit FIFO words, tracks the
// message length and flushes a masked residue word when the message ends.
module sha512_msg_pack
  import hmac512_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         sha_en,
  input  logic         hash_start,
  input  logic         hash_process,
  input  logic         reg_wvalid,
  output logic         reg_wready,
  input  logic [31:0]  reg_wdata,
  input  logic [3:0]   reg_wstrb,
  output logic         fifo_wvalid,
  input  logic         fifo_wready,
  output sha_fifo_t    fifo_wdata,
  output logic [127:0] message_length,
  output logic         err_strb,
  output logic         pack_done
);

  pack_st_e     state_q, state_d;
  logic [3:0]   ptr_q, ptr_d;
  logic         sealed_q, sealed_d;
  sha_word_t    hold_q, hold_d;
  sha_fifo_t    out_q, out_d;
  logic         out_vld_q, out_vld_d;
  logic [127:0] len_q, len_d;
  logic         err_q, err_d;

  strb_info_t   info;
  logic         wr_fire;
  logic         out_free;

  assign info       = decode_strb(reg_wstrb);
  assign reg_wready = (state_q == StAccum) && !sealed_q && !(ptr_q == 4'd8 && out_vld_q);
  assign wr_fire    = reg_wvalid && reg_wready;
  assign out_free   = !out_vld_q || fifo_wready;

  always_comb begin
    // NOTE: every *_d takes its current value first, so no branch can leave a latch behind.
    state_d   = state_q;
    ptr_d     = ptr_q;
    sealed_d  = sealed_q;
    hold_d    = hold_q;
    out_d     = out_q;
    out_vld_d = out_vld_q;
    len_d     = len_q;
    err_d     = 1'b0;

    if (out_vld_q && fifo_wready) out_vld_d = 1'b0;

    if (wr_fire) begin
      if (!info.legal) begin
        err_d = 1'b1;
      end else begin
        // ptr is 0 or 4 here, so ptr+i never passes slot 7.
        for (int i = 0; i < 4; i++) begin
          if (i < int'(info.nbytes))
            hold_d[8*(7 - int'(ptr_q[2:0]) - i) +: 8] = reg_wdata[8*i +: 8];
        end
        ptr_d = ptr_q + {1'b0, info.nbytes};
        len_d = len_q + {122'd0, info.nbytes, 3'b000};
        if (info.nbytes != 3'd0 && info.nbytes != 3'd4) sealed_d = 1'b1;
      end
    end

    // A full holding word moves as soon as the output register is or becomes free.
    if (ptr_d == 4'd8 && out_free) begin
      out_d     = '{data: hold_d, mask: 8'hFF};
      out_vld_d = 1'b1;
      hold_d    = '0;
      ptr_d     = 4'd0;
    end

    case (state_q)
      StAccum: if (hash_process) state_d = StFlush;
      StFlush: begin
        if (ptr_q != 4'd8 && !out_vld_q) begin
          if (ptr_q == 4'd0) begin
            state_d = StDone;
          end else begin
            out_d     = '{data: hold_q, mask: residue_mask(ptr_q)};
            out_vld_d = 1'b1;
            hold_d    = '0;
            ptr_d     = 4'd0;
            state_d   = StDrain;
          end
        end
      end
      StDrain: if (fifo_wready) state_d = StDone;
      default: ;
    endcase

    if (hash_start || !sha_en) begin
      state_d   = sha_en ? StAccum : StIdle;
      ptr_d     = 4'd0;
      sealed_d  = 1'b0;
      hold_d    = '0;
      out_d     = '0;
      out_vld_d = 1'b0;
      len_d     = '0;
      err_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      ptr_q     <= 4'd0;
      sealed_q  <= 1'b0;
      // NOTE: the holding word is a plain register, not a RAM, and is reset so stale bytes never reach a residue.
      hold_q    <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      len_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from pre-edge values together.
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sealed_q  <= sealed_d;
      hold_q    <= hold_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      len_q     <= len_d;
      err_q     <= err_d;
    end
  end

  assign fifo_wvalid    = out_vld_q;
  assign fifo_wdata     = out_q;
  assign message_length = len_q;
  assign err_strb       = err_q;
  assign pack_done      = (state_q == StDone);

endmodule

// File: tb/tb_sha512_msg_pack.sv
// Self-checking bench for sha512_msg_pack: directed flows plus random messages
// compared against a byte-stream reference model.
module tb_sha512_msg_pack;
  import hmac512_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         sha_en = 1'b0;
  logic         hash_start = 1'b0;
  logic         hash_process = 1'b0;
  logic         reg_wvalid = 1'b0;
  logic         reg_wready;
  logic [31:0]  reg_wdata = '0;
  logic [3:0]   reg_wstrb = '0;
  logic         fifo_wvalid;
  logic         fifo_wready = 1'b0;
  sha_fifo_t    fifo_wdata;
  logic [127:0] message_length;
  logic         err_strb;
  logic         pack_done;

  int total = 0;
  int bad   = 0;

  // Reference model: message bytes in arrival order, expected and observed pushes.
  logic [7:0]   m_bytes[$];
  sha_fifo_t    exp_q[$];
  sha_fifo_t    got_q[$];
  logic [127:0] m_len = '0;

  sha512_msg_pack dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .sha_en         (sha_en),
    .hash_start     (hash_start),
    .hash_process   (hash_process),
    .reg_wvalid     (reg_wvalid),
    .reg_wready     (reg_wready),
    .reg_wdata      (reg_wdata),
    .reg_wstrb      (reg_wstrb),
    .fifo_wvalid    (fifo_wvalid),
    .fifo_wready    (fifo_wready),
    .fifo_wdata     (fifo_wdata),
    .message_length (message_length),
    .err_strb       (err_strb),
    .pack_done      (pack_done)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i)
    if (rst_ni && fifo_wvalid && fifo_wready) got_q.push_back(fifo_wdata);

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [3:0] s);
    return (s == 4'd0) || (s == 4'd1) || (s == 4'd3) || (s == 4'd7) || (s == 4'd15);
  endfunction

  // Pop k message bytes into one word, first byte in the top byte.
  function automatic sha_fifo_t make_word(input int k);
    sha_fifo_t w;
    w.data = '0;
    for (int j = 0; j < 8; j++) begin
      w.data = w.data << 8;
      if (j < k) w.data[7:0] = m_bytes.pop_front();
    end
    w.mask = 8'hFF << (8 - k);
    return w;
  endfunction

  task automatic model_write(input logic [31:0] d, input logic [3:0] s);
    int n;
    if (!is_legal(s)) return;
    n = $countones(s);
    for (int i = 0; i < n; i++) m_bytes.push_back(d[8*i +: 8]);
    m_len = m_len + 128'(8 * n);
    while (m_bytes.size() >= 8) exp_q.push_back(make_word(8));
  endtask

  task automatic model_flush();
    if (m_bytes.size() > 0) exp_q.push_back(make_word(m_bytes.size()));
  endtask

  task automatic model_start();
    m_bytes.delete();
    exp_q.delete();
    got_q.delete();
    m_len = '0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Starts and ends on a falling edge; optionally pulses hash_process with the transfer.
  task automatic wr(input logic [31:0] d, input logic [3:0] s, input bit proc);
    int n;
    bit acc;
    n = 0;
    reg_wvalid = 1'b1;
    reg_wdata  = d;
    reg_wstrb  = s;
    while (!reg_wready && n < 100) begin
      if (n == 8) fifo_wready = 1'b1;
      @(negedge clk_i);
      n++;
    end
    check("wr_ready", reg_wready, 1'b1);
    acc = reg_wready;
    hash_process = proc;
    @(posedge clk_i);
    if (acc) model_write(d, s);
    if (proc) model_flush();
    @(negedge clk_i);
    reg_wvalid   = 1'b0;
    hash_process = 1'b0;
  endtask

  task automatic pulse(input bit start, input bit proc);
    hash_start   = start;
    hash_process = proc;
    @(negedge clk_i);
    hash_start   = 1'b0;
    hash_process = 1'b0;
    if (start) model_start();
    else if (proc) model_flush();
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!pack_done && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    check(tag, pack_done, 1'b1);
  endtask

  task automatic cmp_pushes(input string tag);
    int n;
    check($sformatf("%s_count", tag), got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data%0d", tag, i), got_q[i].data, exp_q[i].data);
      check($sformatf("%s_mask%0d", tag, i), got_q[i].mask, exp_q[i].mask);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    sha_fifo_t   g;
    logic [3:0]  s;
    int          nw;
    int          r;
    bit          flushed;
    bit          proc;

    // Reset state
    sha_en = 1'b1;
    tick(2);
    check("rst_wready",  reg_wready,     1'b0);
    check("rst_fvalid",  fifo_wvalid,    1'b0);
    check("rst_fdata",   fifo_wdata,     '0);
    check("rst_len",     message_length, '0);
    check("rst_err",     err_strb,       1'b0);
    check("rst_done",    pack_done,      1'b0);
    rst_ni = 1'b1;
    tick(1);
    check("idle_wready", reg_wready, 1'b0);

    // One full word
    pulse(1, 0);
    check("start_wready", reg_wready, 1'b1);
    fifo_wready = 1'b1;
    wr(32'h03020100, 4'hF, 0);
    wr(32'h07060504, 4'hF, 0);
    tick(3);
    g = (got_q.size() > 0) ? got_q[0] : '0;
    check("full_data", g.data, 64'h0001020304050607);
    check("full_mask", g.mask, 8'hFF);
    check("full_len",  message_length, 128'd64);
    cmp_pushes("full");

    // Partial write seals, then residue flush
    pulse(1, 0);
    wr(32'h03020100, 4'hF, 0);
    wr(32'h00000504, 4'h3, 0);
    check("seal_wready", reg_wready, 1'b0);
    pulse(0, 1);
    wait_done("part_done");
    g = (got_q.size() > 0) ? got_q[0] : '0;
    check("part_data", g.data, 64'h0001020304050000);
    check("part_mask", g.mask, 8'hFC);
    check("part_len",  message_length, 128'd48);
    cmp_pushes("part");

    // Illegal strobe
    pulse(1, 0);
    wr(32'hAABBCCDD, 4'h5, 0);
    check("ill_err",  err_strb, 1'b1);
    tick(1);
    check("ill_err_drop", err_strb, 1'b0);
    check("ill_len",      message_length, '0);
    tick(2);
    cmp_pushes("ill");

    // Backpressure: output plus holding fill after 4 writes
    pulse(1, 0);
    fifo_wready = 1'b0;
    for (int i = 0; i < 4; i++) wr($urandom, 4'hF, 0);
    check("bp_wready", reg_wready, 1'b0);
    check("bp_valid",  fifo_wvalid, 1'b1);
    check("bp_data0",  fifo_wdata, exp_q[0]);
    tick(5);
    check("bp_data1",   fifo_wdata, exp_q[0]);
    check("bp_wready1", reg_wready, 1'b0);
    fifo_wready = 1'b1;
    for (int i = 0; i < 12; i++) wr($urandom, 4'hF, 0);
    tick(4);
    check("bp_words", got_q.size(), 8);
    cmp_pushes("bp");

    // hash_start with hash_process mid-message
    pulse(1, 0);
    for (int i = 0; i < 3; i++) wr($urandom, 4'hF, 0);
    tick(2);
    cmp_pushes("restart_pre");
    pulse(1, 1);
    tick(3);
    check("restart_valid",  fifo_wvalid, 1'b0);
    check("restart_len",    message_length, '0);
    check("restart_done",   pack_done, 1'b0);
    check("restart_wready", reg_wready, 1'b1);
    check("restart_pushes", got_q.size(), 0);

    // Full word pending when hash_process arrives
    pulse(1, 0);
    fifo_wready = 1'b0;
    wr($urandom, 4'hF, 0);
    wr($urandom, 4'hF, 0);
    check("pend_valid", fifo_wvalid, 1'b1);
    pulse(0, 1);
    tick(3);
    check("pend_notdone", pack_done, 1'b0);
    fifo_wready = 1'b1;
    wait_done("pend_done");
    check("pend_drained", fifo_wvalid, 1'b0);
    cmp_pushes("pend");

    // Abort by dropping sha_en with output pending
    pulse(1, 0);
    fifo_wready = 1'b0;
    for (int i = 0; i < 3; i++) wr($urandom, 4'hF, 0);
    sha_en = 1'b0;
    tick(1);
    check("abort_valid",  fifo_wvalid, 1'b0);
    check("abort_wready", reg_wready, 1'b0);
    check("abort_len",    message_length, '0);
    sha_en = 1'b1;
    tick(2);
    check("abort_idle", reg_wready, 1'b0);
    check("abort_pushes", got_q.size(), 0);
    model_start();

    // Random messages
    for (int m = 0; m < 10; m++) begin
      pulse(1, 0);
      fifo_wready = 1'($urandom_range(0, 1));
      nw = $urandom_range(1, 9);
      flushed = 1'b0;
      for (int w = 0; w < nw; w++) begin
        r = $urandom_range(0, 9);
        if (r <= 5) s = 4'hF;
        else if (r == 6) s = 4'h0;
        else if (r == 7) begin
          do s = 4'($urandom_range(0, 15)); while (is_legal(s));
        end else begin
          r = $urandom_range(0, 2);
          s = (r == 0) ? 4'h1 : (r == 1) ? 4'h3 : 4'h7;
        end
        proc = (w == nw - 1 || s inside {4'h1, 4'h3, 4'h7}) && ($urandom_range(0, 1) == 1);
        wr($urandom, s, proc);
        if (!is_legal(s)) check($sformatf("rnd%0d_err", m), err_strb, 1'b1);
        fifo_wready = 1'($urandom_range(0, 1));
        if (proc) begin
          flushed = 1'b1;
          break;
        end
        if (s inside {4'h1, 4'h3, 4'h7}) break;
      end
      if (!flushed) pulse(0, 1);
      fifo_wready = 1'b1;
      wait_done($sformatf("rnd%0d_done", m));
      tick(2);
      cmp_pushes($sformatf("rnd%0d", m));
      check($sformatf("rnd%0d_len", m), message_length, m_len);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
